// File: rtl/am9513_bus_if_if.sv
// CPU-side request/acknowledge and Am9513 timer-side strobe/data signals of the bus sequencer.
interface am9513_bus_if_if;
  logic        cpu_sel;
  logic        cpu_rw;
  logic        cpu_a1;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_dtack;
  logic        tmr_cs_n;
  logic        tmr_cd_n;
  logic        tmr_rd_n;
  logic        tmr_wr_n;
  logic [15:0] tmr_d_out;
  logic        tmr_d_oe;
  logic [15:0] tmr_d_in;

  modport master (
    output cpu_sel, cpu_rw, cpu_a1, cpu_wdata, tmr_d_in,
    input  cpu_rdata, cpu_dtack, tmr_cs_n, tmr_cd_n, tmr_rd_n, tmr_wr_n, tmr_d_out, tmr_d_oe
  );

  modport slave (
    input  cpu_sel, cpu_rw, cpu_a1, cpu_wdata, tmr_d_in,
    output cpu_rdata, cpu_dtack, tmr_cs_n, tmr_cd_n, tmr_rd_n, tmr_wr_n, tmr_d_out, tmr_d_oe
  );
endinterface

// File: rtl/am9513_bus_if.sv
// Sequences one CPU access into Am9513 CS/CD/RD/WR strobes with setup, width and recovery timing.
module am9513_bus_if #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 3,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  am9513_bus_if_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK, RECOVER} state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] REC_LAST    = 4'(RECOVERY_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        rw_q, rw_nxt;
  logic        cs_n, cd_n, rd_n, wr_n, d_oe, dtack;
  logic        cs_n_nxt, cd_n_nxt, rd_n_nxt, wr_n_nxt, d_oe_nxt, dtack_nxt;
  logic [15:0] d_out, rdata, d_out_nxt, rdata_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rw_q  <= 1'b0;
      cs_n  <= 1'b1;
      cd_n  <= 1'b1;
      rd_n  <= 1'b1;
      wr_n  <= 1'b1;
      d_oe  <= 1'b0;
      dtack <= 1'b0;
      d_out <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rw_q  <= rw_nxt;
      cs_n  <= cs_n_nxt;
      cd_n  <= cd_n_nxt;
      rd_n  <= rd_n_nxt;
      wr_n  <= wr_n_nxt;
      d_oe  <= d_oe_nxt;
      dtack <= dtack_nxt;
      d_out <= d_out_nxt;
      rdata <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    if (bus.cpu_sel) begin state_nxt = SETUP; cnt_nxt = '0; end
      SETUP:   if (cnt == SETUP_LAST) begin state_nxt = STROBE; cnt_nxt = '0; end
               else cnt_nxt = cnt + 4'd1;
      STROBE:  if (cnt == STROBE_LAST) begin state_nxt = HOLD; cnt_nxt = '0; end
               else cnt_nxt = cnt + 4'd1;
      HOLD:    state_nxt = ACK;
      ACK:     if (!bus.cpu_sel) begin state_nxt = RECOVER; cnt_nxt = '0; end
      RECOVER: if (cnt == REC_LAST) begin state_nxt = IDLE; cnt_nxt = '0; end
               else cnt_nxt = cnt + 4'd1;
      default: begin state_nxt = IDLE; cnt_nxt = '0; end
    endcase
  end

  // Next values of the registered outputs; everything holds unless a transition edits it.
  always_comb begin
    rw_nxt    = rw_q;
    cs_n_nxt  = cs_n;
    cd_n_nxt  = cd_n;
    rd_n_nxt  = rd_n;
    wr_n_nxt  = wr_n;
    d_oe_nxt  = d_oe;
    dtack_nxt = dtack;
    d_out_nxt = d_out;
    rdata_nxt = rdata;
    case (state)
      IDLE: if (bus.cpu_sel) begin
        rw_nxt    = bus.cpu_rw;
        cs_n_nxt  = 1'b0;
        cd_n_nxt  = bus.cpu_a1;
        d_out_nxt = bus.cpu_wdata;
        d_oe_nxt  = ~bus.cpu_rw;
      end
      SETUP: if (cnt == SETUP_LAST) begin
        rd_n_nxt = ~rw_q;
        wr_n_nxt = rw_q;
      end
      STROBE: if (cnt == STROBE_LAST) begin
        rd_n_nxt = 1'b1;
        wr_n_nxt = 1'b1;
        if (rw_q) rdata_nxt = bus.tmr_d_in;
      end
      HOLD: begin
        cs_n_nxt  = 1'b1;
        d_oe_nxt  = 1'b0;
        dtack_nxt = 1'b1;
      end
      ACK: if (!bus.cpu_sel) dtack_nxt = 1'b0;
      default: ;
    endcase
  end

  assign bus.tmr_cs_n  = cs_n;
  assign bus.tmr_cd_n  = cd_n;
  assign bus.tmr_rd_n  = rd_n;
  assign bus.tmr_wr_n  = wr_n;
  assign bus.tmr_d_oe  = d_oe;
  assign bus.tmr_d_out = d_out;
  assign bus.cpu_rdata = rdata;
  assign bus.cpu_dtack = dtack;
endmodule

// File: doc/am9513_bus_if.md
Name: am9513_bus_if

Overview:
- CPU-side bus sequencer that sits directly upstream of the Am9513 timer model.
- Converts a single-cycle-select, 16-bit CPU access into correctly timed timer strobes: CS_n, CD_n, RD_n, WR_n, plus data-bus drive.
- Returns a DTACK-style acknowledge to the CPU, with read data held stable.
- Enforces Am9513 setup, strobe-width and inter-access recovery times in clk cycles.

Parameters:
- SETUP_CYC, 1, cycles CS_n/CD_n are stable before RD_n/WR_n fall (1..15).
- STROBE_CYC, 3, cycles RD_n/WR_n are held low (1..15).
- RECOVERY_CYC, 2, cycles CS_n stays high after an access before the next may start (1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_sel  input  1  timer access request, level; held until cpu_dtack is seen.
- cpu_rw  input  1  1 = read, 0 = write; sampled with cpu_sel.
- cpu_a1  input  1  address bit 1; 1 = command/status port, 0 = data port.
- cpu_wdata  input  16  write data; sampled with cpu_sel.
- cpu_rdata  output  16  read data, valid while cpu_dtack=1.
- cpu_dtack  output  1  access acknowledge.
- tmr_cs_n  output  1  timer chip select, active low.
- tmr_cd_n  output  1  timer C/D select; equals the latched cpu_a1.
- tmr_rd_n  output  1  timer read strobe, active low.
- tmr_wr_n  output  1  timer write strobe, active low.
- tmr_d_out  output  16  data driven to the timer.
- tmr_d_oe  output  1  1 = drive tmr_d_out onto the timer bus.
- tmr_d_in  input  16  data returned by the timer.

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1, rd_n=1, wr_n=1, cd_n=1, d_oe=0, d_out=0, cpu_rdata=0, cpu_dtack=0, state=IDLE, counter=0.
- Reset mid-access abandons the access: all strobes are high after the reset edge and no dtack is issued.

State machine, with a 4-bit counter:
- IDLE:
  - At an edge where cpu_sel=1: latch rw, a1 and wdata, then go to SETUP.
  - Outputs after that edge: cs_n=0, cd_n=latched a1, d_out=wdata, d_oe=~rw.
- SETUP:
  - Remain for SETUP_CYC edges, then go to STROBE.
  - On entering STROBE: rd_n=0 if read, wr_n=0 if write.
- STROBE:
  - Remain for STROBE_CYC edges, then go to HOLD; strobes return high.
  - For reads, tmr_d_in is captured into cpu_rdata on this exiting edge.
- HOLD:
  - Lasts 1 edge; cs_n, cd_n and d_oe are kept, so write data is held past the WR_n rising edge.
  - Then go to ACK: cs_n=1, d_oe=0, cpu_dtack=1.
- ACK:
  - cpu_dtack=1 and cpu_rdata is stable.
  - At the first edge with cpu_sel=0, go to RECOVER and set cpu_dtack=0.
  - If cpu_sel is already 0 on entering ACK, dtack is still high for exactly one cycle.
- RECOVER:
  - Remain for RECOVERY_CYC edges with cs_n=1, then go to IDLE.
  - cpu_sel high during RECOVER is ignored until IDLE samples it.

Timing and rules:
- Latency: cpu_dtack rises 2+SETUP_CYC+STROBE_CYC edges after cpu_sel is sampled in IDLE (6 with defaults).
- Only one access is in flight; no queueing.
- Changes to cpu_rw, cpu_a1 or cpu_wdata after the IDLE sample have no effect on the current access.
- cpu_sel dropped before dtack: the timer access still completes in full. No dtack is missing and none is extra: one pulse occurs per accepted access.
- rd_n and wr_n are never both low.
- A strobe is never low while cs_n=1.
- d_oe is never 1 during a read.
- cpu_rdata keeps its last value until the next read capture; writes do not alter it.

Test Plan:
- Write command: reset, then cpu_sel=1, rw=0, a1=1, wdata=16'h0b00.
  - Required: cs_n low at edge 1 with cd_n=1, d_oe=1 and d_out=0b00.
  - wr_n low exactly edges 2–4; dtack rises at edge 6.
  - Removing sel gives dtack=0 next edge; cs_n stays high for 2 further edges.
- Read data: rw=1, a1=0, with tmr_d_in=16'h1234 during STROBE.
  - Required: rd_n low 3 cycles, d_oe=0 throughout, cpu_rdata=16'h1234 with dtack at edge 6.
- Back-to-back: keep cpu_sel high (reasserting immediately after dtack drops).
  - Required: second cs_n falls no earlier than RECOVERY_CYC+1 edges after the first dtack drop.
- Abort: drop cpu_sel at edge 2.
  - Required: wr_n still low 3 cycles; dtack high exactly 1 cycle; then RECOVER and IDLE.
- Reset during STROBE: assert reset while wr_n=0.
  - Required: next edge all strobes high, cs_n=1, d_oe=0, dtack=0; a fresh access afterwards behaves as in the first scenario.
- Parameter sweep SETUP_CYC=2, STROBE_CYC=1, RECOVERY_CYC=4.
  - Required: dtack at edge 5; strobe width 1 cycle; recovery 4 cycles.
  - Strobe/CS/OE invariants asserted every cycle.
